nibble_sequencer: RTL and testbench

- Fetch/decode/control sequencer for the 4-bit accumulator processor.
- It is the driving end of the ALU interface: it issues the 3-bit ALU function code and consumes the ALU carry/zero outputs into a flags register.
- It owns the program counter, instruction register, flags and phase FSM.
- It emits load and output-enable strobes for the accumulator, data bus and data RAM.

---
 rtl/nibble_sequencer_pkg.sv | 23 ++
 rtl/nibble_decode.sv | 49 ++++
 rtl/nibble_sequencer.sv | 91 +++++++++
 tb/tb_nibble_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_sequencer_pkg.sv
// nibble_sequencer_pkg: opcode, ALU function and phase encodings shared by the sequencer
package nibble_sequencer_pkg;
  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_HALT} state_e;
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LIT   = 4'h1;
  localparam logic [3:0] OP_ADDI  = 4'h2;
  localparam logic [3:0] OP_CMPI  = 4'h3;
  localparam logic [3:0] OP_NANDI = 4'h4;
  localparam logic [3:0] OP_LD    = 4'h5;
  localparam logic [3:0] OP_ST    = 4'h6;
  localparam logic [3:0] OP_ADDM  = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_JC    = 4'h9;
  localparam logic [3:0] OP_JNC   = 4'hA;
  localparam logic [3:0] OP_JZ    = 4'hB;
  localparam logic [3:0] OP_JNZ   = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hF;
  localparam logic [2:0] ALU_PASSA = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_PASSB = 3'b010;
  localparam logic [2:0] ALU_ADD   = 3'b011;
  localparam logic [2:0] ALU_NAND  = 3'b100;
endpackage

// File: rtl/nibble_decode.sv
// nibble_decode: EXEC-phase opcode decode into datapath strobes, ALU function and jump decision
module nibble_decode
  import nibble_sequencer_pkg::*;
(
  input  logic       exec_i,
  input  logic [3:0] op_i,
  input  logic       flag_c_i,
  input  logic       flag_z_i,
  output logic [2:0] alu_f_o,
  output logic       load_acc_o,
  output logic       load_flags_o,
  output logic       oe_imm_o,
  output logic       oe_alu_o,
  output logic       ram_cs_o,
  output logic       ram_we_o,
  output logic       jump_o,
  output logic       jump_taken_o,
  output logic       halt_o
);
  always_comb begin
    alu_f_o      = ALU_PASSA;
    load_acc_o   = 1'b0;
    load_flags_o = 1'b0;
    oe_imm_o     = 1'b0;
    oe_alu_o     = 1'b0;
    ram_cs_o     = 1'b0;
    ram_we_o     = 1'b0;
    jump_o       = 1'b0;
    jump_taken_o = 1'b0;
    halt_o       = 1'b0;
    if (exec_i)
      case (op_i)
        OP_LIT:   begin oe_imm_o = 1'b1; alu_f_o = ALU_PASSB; load_acc_o = 1'b1; load_flags_o = 1'b1; end
        OP_ADDI:  begin oe_imm_o = 1'b1; alu_f_o = ALU_ADD;   load_acc_o = 1'b1; load_flags_o = 1'b1; end
        OP_CMPI:  begin oe_imm_o = 1'b1; alu_f_o = ALU_SUB;   load_flags_o = 1'b1; end
        OP_NANDI: begin oe_imm_o = 1'b1; alu_f_o = ALU_NAND;  load_acc_o = 1'b1; load_flags_o = 1'b1; end
        OP_LD:    begin ram_cs_o = 1'b1; alu_f_o = ALU_PASSB; load_acc_o = 1'b1; load_flags_o = 1'b1; end
        OP_ST:    begin oe_alu_o = 1'b1; ram_cs_o = 1'b1; ram_we_o = 1'b1; end
        OP_ADDM:  begin ram_cs_o = 1'b1; alu_f_o = ALU_ADD;   load_acc_o = 1'b1; load_flags_o = 1'b1; end
        OP_JMP:   begin jump_o = 1'b1; jump_taken_o = 1'b1; end
        OP_JC:    begin jump_o = 1'b1; jump_taken_o = flag_c_i; end
        OP_JNC:   begin jump_o = 1'b1; jump_taken_o = !flag_c_i; end
        OP_JZ:    begin jump_o = 1'b1; jump_taken_o = flag_z_i; end
        OP_JNZ:   begin jump_o = 1'b1; jump_taken_o = !flag_z_i; end
        OP_HALT:  halt_o = 1'b1;
        default:  ;
      endcase
  end
endmodule

// File: rtl/nibble_sequencer.sv
// nibble_sequencer: fetch/exec/halt sequencer owning pc, ir and flags of the 4-bit accumulator CPU
module nibble_sequencer
  import nibble_sequencer_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [7:0]      rom_data,
  input  logic            alu_c,
  input  logic            alu_z,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      alu_f,
  output logic            load_acc,
  output logic            load_flags,
  output logic            oe_imm,
  output logic            oe_alu,
  output logic            ram_cs,
  output logic            ram_we,
  output logic [3:0]      ram_addr,
  output logic            flag_c,
  output logic            flag_z,
  output logic            halted
);
  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic [7:0]      ir_q, ir_d;
  logic            fc_q, fc_d, fz_q, fz_d;
  logic            jump, jump_taken, halt_op;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      fc_q    <= 1'b0;
      fz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      fc_q    <= fc_d;
      fz_q    <= fz_d;
    end
  end
  assign pc_inc = pc_q + PC_W'(1);
  // In EXEC a jump's target word sits at the already-incremented pc; not taken skips over it.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    fc_d    = fc_q;
    fz_d    = fz_q;
    case (state_q)
      ST_FETCH: begin
        ir_d    = rom_data;
        pc_d    = pc_inc;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = halt_op ? ST_HALT : ST_FETCH;
        pc_d    = !jump ? pc_q : jump_taken ? rom_data[PC_W-1:0] : pc_inc;
        fc_d    = load_flags ? alu_c : fc_q;
        fz_d    = load_flags ? alu_z : fz_q;
      end
      default: ;
    endcase
  end
  nibble_decode u_decode (
    .exec_i       (state_q == ST_EXEC),
    .op_i         (ir_q[7:4]),
    .flag_c_i     (fc_q),
    .flag_z_i     (fz_q),
    .alu_f_o      (alu_f),
    .load_acc_o   (load_acc),
    .load_flags_o (load_flags),
    .oe_imm_o     (oe_imm),
    .oe_alu_o     (oe_alu),
    .ram_cs_o     (ram_cs),
    .ram_we_o     (ram_we),
    .jump_o       (jump),
    .jump_taken_o (jump_taken),
    .halt_o       (halt_op)
  );
  assign pc       = pc_q;
  assign ram_addr = ir_q[3:0];
  assign flag_c   = fc_q;
  assign flag_z   = fz_q;
  assign halted   = state_q == ST_HALT;
  bus_exclusive: assert property (@(posedge clock) disable iff (!reset)
    $onehot0({oe_imm, oe_alu, ram_cs && !ram_we}) && (!ram_we || ram_cs));
endmodule

// File: tb/tb_nibble_sequencer.sv
// tb_nibble_sequencer: ISA-level reference model with a surrounding ALU/accumulator/RAM datapath
module tb_nibble_sequencer;
  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] rom_data;
  logic       alu_c, alu_z;
  logic [7:0] pc;
  logic [2:0] alu_f;
  logic       load_acc, load_flags, oe_imm, oe_alu, ram_cs, ram_we;
  logic [3:0] ram_addr;
  logic       flag_c, flag_z, halted;
  logic [8:0] strb;
  int checks = 0;
  int errors = 0;
  logic [7:0] rom [256];
  logic [3:0] env_ram [16] = '{default: 4'h0};
  logic [3:0] env_acc = 4'h0;
  logic [3:0] bus_b;
  logic [5:0] alu_o;
  logic [7:0] m_pc, m_ir;
  logic       m_fc, m_fz;
  logic [3:0] m_acc = 4'h0;
  logic [3:0] m_ram [16] = '{default: 4'h0};

  nibble_sequencer #(.PC_W(8)) dut (
    .clock(clock), .reset(reset), .rom_data(rom_data), .alu_c(alu_c), .alu_z(alu_z),
    .pc(pc), .alu_f(alu_f), .load_acc(load_acc), .load_flags(load_flags),
    .oe_imm(oe_imm), .oe_alu(oe_alu), .ram_cs(ram_cs), .ram_we(ram_we),
    .ram_addr(ram_addr), .flag_c(flag_c), .flag_z(flag_z), .halted(halted)
  );

  always #5 clock = !clock;

  // ALU semantics of the external datapath: {carry/borrow out, zero, result}
  function automatic logic [5:0] alu(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] r;
    case (f)
      3'b000:  r = {1'b0, a};
      3'b001:  r = {1'b0, a} - {1'b0, b};
      3'b010:  r = {1'b0, b};
      3'b011:  r = {1'b0, a} + {1'b0, b};
      3'b100:  r = {1'b0, ~(a & b)};
      default: r = 5'h0;
    endcase
    return {r[4], r[3:0] == 4'h0, r[3:0]};
  endfunction

  // {alu_f, load_acc, load_flags, oe_imm, oe_alu, ram_cs, ram_we} expected in an EXEC cycle
  function automatic logic [8:0] exp_strb(input logic [3:0] op);
    case (op)
      4'h1:    return 9'b010_1_1_1_0_0_0;
      4'h2:    return 9'b011_1_1_1_0_0_0;
      4'h3:    return 9'b001_0_1_1_0_0_0;
      4'h4:    return 9'b100_1_1_1_0_0_0;
      4'h5:    return 9'b010_1_1_0_0_1_0;
      4'h6:    return 9'b000_0_0_0_1_1_1;
      4'h7:    return 9'b011_1_1_0_0_1_0;
      default: return 9'b0;
    endcase
  endfunction

  assign rom_data = rom[pc];
  assign strb = {alu_f, load_acc, load_flags, oe_imm, oe_alu, ram_cs, ram_we};

  always_comb begin
    bus_b = oe_imm ? ram_addr : (ram_cs && !ram_we) ? env_ram[ram_addr] : 4'h0;
    alu_o = alu(alu_f, env_acc, bus_b);
    alu_c = alu_o[5];
    alu_z = alu_o[4];
  end

  always @(posedge clock) begin
    if (load_acc) env_acc <= alu_o[3:0];
    if (ram_cs && ram_we) env_ram[ram_addr] <= alu_o[3:0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a falling edge; leaves the DUT in FETCH of address 0 at the next falling edge.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_pc", pc, 0);
    check("rst_flags", {flag_c, flag_z}, 0);
    check("rst_strb", strb, 0);
    check("rst_halted", halted, 0);
    @(negedge clock);
    reset = 1'b1;
    m_pc = 8'h00;
    m_fc = 1'b0;
    m_fz = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic run_instrs(input int n, input bit abort_last);
    logic [3:0] op, a, b;
    logic [2:0] f;
    logic [5:0] r;
    logic [7:0] nxt;
    bit is_alu, ld_acc, take, stop;
    stop = 0;
    for (int i = 0; i < n && !stop; i++) begin
      check("fetch_pc", pc, m_pc);
      check("fetch_strb", strb, 0);
      check("fetch_halted", halted, 0);
      check("flag_c", flag_c, m_fc);
      check("flag_z", flag_z, m_fz);
      check("acc", env_acc, m_acc);
      m_ir = rom[m_pc];
      op = m_ir[7:4];
      a = m_ir[3:0];
      nxt = m_pc + 8'd1;
      @(negedge clock);
      check("exec_strb", strb, exp_strb(op));
      check("exec_addr", ram_addr, a);
      check("exec_pc", pc, nxt);
      if (abort_last && i == n - 1) return;
      is_alu = 1;
      ld_acc = 1;
      b = a;
      f = 3'b000;
      case (op)
        4'h1: f = 3'b010;
        4'h2: f = 3'b011;
        4'h3: begin f = 3'b001; ld_acc = 0; end
        4'h4: f = 3'b100;
        4'h5: begin f = 3'b010; b = m_ram[a]; end
        4'h7: begin f = 3'b011; b = m_ram[a]; end
        default: is_alu = 0;
      endcase
      if (is_alu) begin
        r = alu(f, m_acc, b);
        m_fc = r[5];
        m_fz = r[4];
        if (ld_acc) m_acc = r[3:0];
      end
      if (op == 4'h6) m_ram[a] = m_acc;
      take = (op == 4'h8) || (op == 4'h9 && m_fc) || (op == 4'hA && !m_fc) ||
             (op == 4'hB && m_fz) || (op == 4'hC && !m_fz);
      m_pc = (op >= 4'h8 && op <= 4'hC) ? (take ? rom[nxt] : nxt + 8'd1) : nxt;
      @(negedge clock);
      if (op == 4'hF) begin
        for (int k = 0; k < 20; k++) begin
          check("halt_flag", halted, 1);
          check("halt_pc", pc, m_pc);
          check("halt_strb", strb, 0);
          @(negedge clock);
        end
        stop = 1;
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    clear_rom();
    @(negedge clock);
    // ST aborted by reset mid-EXEC: no write, restart from address 0
    rom[0] = 8'h15; rom[1] = 8'h69;
    do_reset();
    run_instrs(2, 1);
    do_reset();
    run_instrs(2, 0);
    // LIT 5 ; ADDI B -> 0x10 sets carry and zero
    clear_rom();
    rom[0] = 8'h15; rom[1] = 8'h2B; rom[2] = 8'hF0;
    do_reset();
    run_instrs(2, 0);
    check("addi_c", flag_c, 1);
    check("addi_z", flag_z, 1);
    run_instrs(5, 0);
    // CMPI equal then JZ taken
    clear_rom();
    rom[0] = 8'h13; rom[1] = 8'h33; rom[2] = 8'hB0; rom[3] = 8'h40; rom[8'h40] = 8'hF0;
    do_reset();
    run_instrs(3, 0);
    check("jz_pc", pc, 8'h40);
    run_instrs(5, 0);
    // JNZ not taken skips the target word
    rom[2] = 8'hC0; rom[4] = 8'hF0;
    do_reset();
    run_instrs(3, 0);
    check("jnz_pc", pc, 8'h04);
    run_instrs(5, 0);
    // ST / LD round trip through RAM address 9
    clear_rom();
    rom[0] = 8'h17; rom[1] = 8'h69; rom[2] = 8'h10; rom[3] = 8'h59; rom[4] = 8'hF0;
    do_reset();
    run_instrs(10, 0);
    check("ld_acc", env_acc, 4'h7);
    // PC wrap FD, FE, FF, then JC not taken skips to 01 (which decodes as HALT)
    clear_rom();
    rom[0] = 8'h80; rom[1] = 8'hFD; rom[8'hFF] = 8'h90;
    do_reset();
    run_instrs(4, 0);
    check("wrap_pc", pc, 8'h01);
    run_instrs(5, 0);
    // Random programs
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
      do_reset();
      run_instrs(150, 0);
    end
    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run still active at %0t, expected to have finished", $time);
    $fatal(1);
  end
endmodule
